// File: rtl/compx_beam_acc.sv
// Complex frame accumulator: sums pr/pi beats per frame, result registered 1 cycle after the closing beat.
// Stalls input while a result waits for out_ready; optional clamping of output via ACC_SAT_EN (wrap when undefined).
module compx_beam_acc #(
    parameter int IW    = 32,
    parameter int OW    = 32,
    parameter int MAXN  = 256,
    parameter int SHIFT = 8,
    localparam int AW   = IW + $clog2(MAXN),
    localparam int CW   = $clog2(MAXN) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [IW-1:0] pr,
    input  logic [IW-1:0] pi,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_r,
    output logic [OW-1:0] out_i,
    output logic [CW-1:0] out_cnt,
    output logic          out_ovf,
    output logic          out_sat
);

    logic signed [AW-1:0] r_acc_r, r_acc_i;
    logic [CW-1:0]        r_cnt;
    logic                 r_out_vld, r_out_ovf, r_out_sat;
    logic [OW-1:0]        r_out_r, r_out_i;
    logic [CW-1:0]        r_out_cnt;

    logic                 w_acc, w_first, w_close;
    logic [CW-1:0]        w_cnt_nxt;
    logic signed [AW-1:0] w_ext_r, w_ext_i, w_sum_r, w_sum_i, w_shr_r, w_shr_i;
    logic [OW-1:0]        w_red_r, w_red_i;
    logic                 w_sat_r, w_sat_i;

    assign in_ready  = !r_out_vld || out_ready;
    assign w_acc     = in_valid && in_ready;
    // r_cnt == 0 marks frame start, so the stale accumulator is bypassed rather than cleared
    assign w_first   = (r_cnt == '0);
    assign w_cnt_nxt = r_cnt + CW'(1);
    assign w_close   = w_acc && (in_last || (w_cnt_nxt == CW'(MAXN)));

    assign w_ext_r = {{(AW-IW){pr[IW-1]}}, pr};
    assign w_ext_i = {{(AW-IW){pi[IW-1]}}, pi};
    assign w_sum_r = w_first ? w_ext_r : r_acc_r + w_ext_r;
    assign w_sum_i = w_first ? w_ext_i : r_acc_i + w_ext_i;
    assign w_shr_r = w_sum_r >>> SHIFT;
    assign w_shr_i = w_sum_i >>> SHIFT;

`ifdef ACC_SAT_EN
    localparam logic signed [AW-1:0] L_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] L_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        w_red_r = w_shr_r[OW-1:0];
        w_red_i = w_shr_i[OW-1:0];
        w_sat_r = 1'b0;
        w_sat_i = 1'b0;
        if (w_shr_r > L_MAX) begin
            w_red_r = L_MAX[OW-1:0];
            w_sat_r = 1'b1;
        end else if (w_shr_r < L_MIN) begin
            w_red_r = L_MIN[OW-1:0];
            w_sat_r = 1'b1;
        end
        if (w_shr_i > L_MAX) begin
            w_red_i = L_MAX[OW-1:0];
            w_sat_i = 1'b1;
        end else if (w_shr_i < L_MIN) begin
            w_red_i = L_MIN[OW-1:0];
            w_sat_i = 1'b1;
        end
    end
`else
    logic w_unused;
    assign w_red_r  = w_shr_r[OW-1:0];
    assign w_red_i  = w_shr_i[OW-1:0];
    assign w_sat_r  = 1'b0;
    assign w_sat_i  = 1'b0;
    assign w_unused = ^{w_shr_r[AW-1:OW], w_shr_i[AW-1:OW]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_r   <= '0;
            r_acc_i   <= '0;
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
            r_out_r   <= '0;
            r_out_i   <= '0;
            r_out_cnt <= '0;
            r_out_ovf <= 1'b0;
            r_out_sat <= 1'b0;
        end else begin
            if (w_acc) begin
                if (w_close) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt   <= w_cnt_nxt;
                    r_acc_r <= w_sum_r;
                    r_acc_i <= w_sum_i;
                end
            end
            // close can only occur while in_ready, so a held result is never overwritten
            if (w_close) begin
                r_out_vld <= 1'b1;
                r_out_r   <= w_red_r;
                r_out_i   <= w_red_i;
                r_out_cnt <= w_cnt_nxt;
                r_out_ovf <= !in_last;
                r_out_sat <= w_sat_r | w_sat_i;
            end else if (r_out_vld && out_ready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_r     = r_out_r;
    assign out_i     = r_out_i;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_compx_beam_acc.sv
// Directed bench for compx_beam_acc: main instance SHIFT=0/MAXN=256, second instance SHIFT=2/MAXN=4 for scaling.
module tb_compx_beam_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, out_ready;
    logic [31:0] pr, pi;
    logic        in_ready, out_valid, out_ovf, out_sat;
    logic [31:0] out_r, out_i;
    logic [8:0]  out_cnt;
    logic        in_ready2, out_valid2, out_ovf2, out_sat2;
    logic [31:0] out_r2, out_i2;
    logic [2:0]  out_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    compx_beam_acc #(.IW(32), .OW(32), .MAXN(256), .SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .pr(pr), .pi(pi), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_i(out_i), .out_cnt(out_cnt), .out_ovf(out_ovf), .out_sat(out_sat)
    );

    compx_beam_acc #(.IW(32), .OW(32), .MAXN(4), .SHIFT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
        .pr(pr), .pi(pi), .out_valid(out_valid2), .out_ready(out_ready), .out_r(out_r2),
        .out_i(out_i2), .out_cnt(out_cnt2), .out_ovf(out_ovf2), .out_sat(out_sat2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat, let it be taken at the next edge, return 1 time unit after that edge
    task automatic send(input logic [31:0] r, input logic [31:0] i, input logic last);
        in_valid = 1'b1;
        pr       = r;
        pi       = i;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; pr = '0; pi = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_r",     out_r, 32'd0);
        chk("rst_cnt",   32'(out_cnt), 32'd0);
        chk("rst_flags", {30'd0, out_ovf, out_sat}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // four-beat frame, plus scaled view with floor on the negative side
        send(32'd1, 32'hFFFF_FFFF, 1'b0);
        send(32'd2, 32'hFFFF_FFFE, 1'b0);
        send(32'd3, 32'hFFFF_FFFD, 1'b0);
        chk("f4_no_early_valid", 32'(out_valid), 32'd0);
        send(32'd4, 32'hFFFF_FFFC, 1'b1);
        chk("f4_valid", 32'(out_valid), 32'd1);
        chk("f4_r",     out_r, 32'd10);
        chk("f4_i",     out_i, 32'hFFFF_FFF6);
        chk("f4_cnt",   32'(out_cnt), 32'd4);
        chk("f4_ovf",   32'(out_ovf), 32'd0);
        chk("f4_sat",   32'(out_sat), 32'd0);
        chk("sh2_r",    out_r2, 32'd2);
        chk("sh2_i",    out_i2, 32'hFFFF_FFFD);
        chk("sh2_cnt",  32'(out_cnt2), 32'd4);
        chk("sh2_ovf",  32'(out_ovf2), 32'd0);
        idle();
        chk("f4_valid_one_cycle", 32'(out_valid), 32'd0);

        // single-beat frame then a back-to-back frame with bubbles
        send(32'hFFFF_FFFB, 32'd7, 1'b1);
        chk("f1_r",   out_r, 32'hFFFF_FFFB);
        chk("f1_i",   out_i, 32'd7);
        chk("f1_cnt", 32'(out_cnt), 32'd1);
        send(32'd100, 32'd200, 1'b0);
        chk("b2b_valid_clear", 32'(out_valid), 32'd0);
        idle();
        idle();
        send(32'd1, 32'd1, 1'b1);
        chk("b2b_r",   out_r, 32'd101);
        chk("b2b_i",   out_i, 32'd201);
        chk("b2b_cnt", 32'(out_cnt), 32'd2);
        idle();

        // backpressure: result holds, no beat taken, then close coincides with handshake
        out_ready = 1'b0;
        send(32'd5, 32'd6, 1'b1);
        chk("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1; pr = 32'd99; pi = 32'd99; in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_v",   32'(out_valid), 32'd1);
            chk("bp_hold_r",   out_r, 32'd5);
            chk("bp_hold_i",   out_i, 32'd6);
            chk("bp_hold_cnt", 32'(out_cnt), 32'd1);
        end
        out_ready = 1'b1;
        send(32'd7, 32'd8, 1'b1);
        chk("bp_reload_valid", 32'(out_valid), 32'd1);
        chk("bp_reload_r",     out_r, 32'd7);
        chk("bp_reload_i",     out_i, 32'd8);
        chk("bp_reload_cnt",   32'(out_cnt), 32'd1);
        idle();
        chk("bp_drain", 32'(out_valid), 32'd0);

        // forced close at MAXN
        for (int k = 0; k < 255; k++) send(32'd1, 32'd0, 1'b0);
        chk("max_not_yet", 32'(out_valid), 32'd0);
        send(32'd1, 32'd0, 1'b0);
        chk("max_valid", 32'(out_valid), 32'd1);
        chk("max_r",     out_r, 32'd256);
        chk("max_cnt",   32'(out_cnt), 32'd256);
        chk("max_ovf",   32'(out_ovf), 32'd1);
        send(32'd2, 32'd0, 1'b1);
        chk("max_next_r",   out_r, 32'd2);
        chk("max_next_cnt", 32'(out_cnt), 32'd1);
        chk("max_next_ovf", 32'(out_ovf), 32'd0);

        // reduction to OW bits: positive and negative overrange
        send(32'h7FFF_FFFF, 32'd0, 1'b0);
        send(32'h7FFF_FFFF, 32'd0, 1'b1);
`ifdef ACC_SAT_EN
        chk("pos_r",   out_r, 32'h7FFF_FFFF);
        chk("pos_sat", 32'(out_sat), 32'd1);
`else
        chk("pos_r",   out_r, 32'hFFFF_FFFE);
        chk("pos_sat", 32'(out_sat), 32'd0);
`endif
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b1);
`ifdef ACC_SAT_EN
        chk("neg_r",   out_r, 32'h8000_0000);
        chk("neg_i",   out_i, 32'h8000_0000);
        chk("neg_sat", 32'(out_sat), 32'd1);
`else
        chk("neg_r",   out_r, 32'h0000_0000);
        chk("neg_i",   out_i, 32'h0000_0000);
        chk("neg_sat", 32'(out_sat), 32'd0);
`endif

        // async reset mid-frame discards the partial sum
        send(32'd1, 32'd1, 1'b0);
        send(32'd2, 32'd2, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_r",     out_r, 32'd0);
        chk("ar_i",     out_i, 32'd0);
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_ready", 32'(in_ready), 32'd1);
        chk("ar_cnt",   32'(out_cnt), 32'd0);
        chk("ar_flags", {30'd0, out_ovf, out_sat}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'd10, 32'd20, 1'b0);
        send(32'd20, 32'd20, 1'b0);
        send(32'd30, 32'd20, 1'b0);
        send(32'd40, 32'd20, 1'b1);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_r",     out_r, 32'd100);
        chk("post_rst_i",     out_i, 32'd80);
        chk("post_rst_cnt",   32'(out_cnt), 32'd4);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
